// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync inputs and recovered timing outputs of the VGA sync decoder
// master: sync source / consumer side (drives hsync, vsync; reads results)
// slave : decoder side (reads hsync, vsync; drives pixh, pixv, dis_en, locked, err, frame_start, line_len)
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [10:0] pixh;
  logic [9:0]  pixv;
  logic        dis_en;
  logic        locked;
  logic        err;
  logic        frame_start;
  logic [10:0] line_len;
  modport master (
    output hsync, vsync,
    input  pixh, pixv, dis_en, locked, err, frame_start, line_len
  );
  modport slave (
    input  hsync, vsync,
    output pixh, pixv, dis_en, locked, err, frame_start, line_len
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds h/v counters from an hsync/vsync stream, checks geometry, reports lock
// Ports:
//   clk  pixel clock
//   clr  synchronous active-low reset
//   bus  slave side: hsync/vsync in; pixh, pixv, dis_en, locked, err, frame_start, line_len out
module vga_sync_decoder #(
  parameter int HPIX        = 1056,
  parameter int HSP         = 128,
  parameter int HACT        = 256,
  parameter int VPIX        = 628,
  parameter int VSP         = 4,
  parameter int VACT        = 27,
  parameter int VFP         = 627,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               clr,
  vga_sync_decoder_if.slave  bus
);
  localparam logic [10:0] H_LAST     = 11'(HPIX - 1);
  localparam logic [10:0] H_SYNC_END = 11'(HSP - 1);
  localparam logic [10:0] H_ACT      = 11'(HACT);
  localparam logic [10:0] H_END      = 11'(HPIX);
  localparam logic [9:0]  V_LAST     = 10'(VPIX - 1);
  // the active area never starts inside the vsync pulse
  localparam logic [9:0]  V_ACT      = 10'(VACT > VSP ? VACT : VSP);
  localparam logic [9:0]  V_END      = 10'(VFP);
  localparam int          GW         = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] G_LOCK   = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic        hs1_q, hs2_q, vs1_q, vs2_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hr_ok_q, hr_ok_d;
  logic        vf_pend_q, vf_pend_d;
  logic        frame_bad_q, frame_bad_d;
  logic [10:0] line_len_q, line_len_d;
  logic [10:0] pixh_q, pixh_d;
  logic [9:0]  pixv_q, pixv_d;
  logic        dis_en_q, dis_en_d;
  logic        frame_start_q, frame_start_d;
  state_t      state_q;
  logic [GW-1:0] good_cnt_q;
  logic        locked_q, err_q;
  logic        hf, hr, vf, line_good, restart, frame_good, timeout;

  always_comb begin
    hf            = hs2_q & ~hs1_q;
    hr            = ~hs2_q & hs1_q;
    vf            = vs2_q & ~vs1_q;
    line_good     = hcnt_q == H_LAST && hr_ok_q;
    // a vsync fall landing on the same hf is honoured on that hf
    restart       = hf && (vf_pend_q || vf);
    // the line closing the frame belongs to it, so its check is folded in here
    frame_good    = vcnt_q == V_LAST && !frame_bad_q && line_good;
    // an hf arriving on the saturated count restarts the line instead of timing out
    timeout       = hcnt_q == 11'h7ff && !hf;
    hcnt_d        = hf ? 11'd0 : (hcnt_q == 11'h7ff ? hcnt_q : hcnt_q + 11'd1);
    hr_ok_d       = hr ? hcnt_q == H_SYNC_END : (hf ? 1'b0 : hr_ok_q);
    vf_pend_d     = restart ? 1'b0 : vf_pend_q | vf;
    vcnt_d        = restart ? 10'd0 : (hf && vcnt_q != 10'h3ff ? vcnt_q + 10'd1 : vcnt_q);
    frame_bad_d   = restart ? 1'b0 : frame_bad_q | (hf & ~line_good);
    line_len_d    = hf ? hcnt_q + 11'd1 : line_len_q;
    frame_start_d = restart;
    dis_en_d      = locked_q && hcnt_q >= H_ACT && hcnt_q < H_END && vcnt_q >= V_ACT && vcnt_q < V_END;
    // coordinates only move inside the active window and hold outside it
    pixh_d        = dis_en_d ? hcnt_q - H_ACT : pixh_q;
    pixv_d        = dis_en_d ? vcnt_q - V_ACT : pixv_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hr_ok_q       <= 1'b0;
      vf_pend_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      line_len_q    <= '0;
      pixh_q        <= '0;
      pixv_q        <= '0;
      dis_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs1_q         <= bus.hsync;
      hs2_q         <= hs1_q;
      vs1_q         <= bus.vsync;
      vs2_q         <= vs1_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hr_ok_q       <= hr_ok_d;
      vf_pend_q     <= vf_pend_d;
      frame_bad_q   <= frame_bad_d;
      line_len_q    <= line_len_d;
      pixh_q        <= pixh_d;
      pixv_q        <= pixv_d;
      dis_en_q      <= dis_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (timeout) begin
        state_q    <= SEARCH;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
        err_q      <= state_q == LOCKED;
      end else begin
        case (state_q)
          SEARCH: if (restart) begin
            state_q    <= TRACK;
            good_cnt_q <= '0;
          end
          TRACK: if (restart) begin
            if (frame_good) begin
              good_cnt_q <= good_cnt_q + 1'b1;
              if (good_cnt_q + 1'b1 == G_LOCK) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
          LOCKED: if ((hf && !line_good) || (restart && !frame_good)) begin
            state_q    <= TRACK;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b1;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus.pixh        = pixh_q;
  assign bus.pixv        = pixv_q;
  assign bus.dis_en      = dis_en_q;
  assign bus.locked      = locked_q;
  assign bus.err         = err_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_len    = line_len_q;
endmodule
